// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-controller port arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (consumed by mem_arb_select
// and mem_port_arbiter).
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CLRWAIT,
        ST_DONE
    } arb_state_t;

    typedef logic [1:0] ctrl_t;
    typedef logic [1:0] req_id_t;

    localparam ctrl_t CTRL_CLR = 2'b00;
    localparam ctrl_t CTRL_NOP = 2'b01;
    localparam ctrl_t CTRL_RD  = 2'b10;
    localparam ctrl_t CTRL_WR  = 2'b11;

    localparam req_id_t REQ_CLR = 2'd0;
    localparam req_id_t REQ_D   = 2'd1;
    localparam req_id_t REQ_IF  = 2'd2;

    // An indirect access makes the controller do a pointer pass and a data pass.
    function automatic logic [1:0] pulses_needed(input logic indirect);
        return indirect ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request/response and cache-controller signals of the memory port arbiter.
// slave: the arbiter's view. master: the core and cache controller's view.
interface mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              clrReq;
    logic              clrDone;
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifDone;
    logic [DATA_W-1:0] ifData;
    logic              dReq;
    logic              dWrite;
    logic              dIndirect;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dDone;
    logic [DATA_W-1:0] dRdata;
    logic [1:0]        cacheCtrl;
    logic              cacheIndirect;
    logic              cacheCommence;
    logic [ADDR_W-1:0] cacheAddr;
    logic [DATA_W-1:0] cacheWdata;
    logic              cacheOutputReady;
    logic [DATA_W-1:0] cacheRdata;

    modport slave (
        input  clrReq, ifReq, ifAddr, dReq, dWrite, dIndirect, dAddr, dWdata,
               cacheOutputReady, cacheRdata,
        output clrDone, ifDone, ifData, dDone, dRdata,
               cacheCtrl, cacheIndirect, cacheCommence, cacheAddr, cacheWdata
    );

    modport master (
        output clrReq, ifReq, ifAddr, dReq, dWrite, dIndirect, dAddr, dWdata,
               cacheOutputReady, cacheRdata,
        input  clrDone, ifDone, ifData, dDone, dRdata,
               cacheCtrl, cacheIndirect, cacheCommence, cacheAddr, cacheWdata
    );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner pick among clear, data and fetch requests.
// Clear always wins. With MEM_ARB_ROUND_ROBIN_EN defined, a data/fetch tie
// is broken by the round-robin pointer; otherwise data beats fetch.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic    i_clr_req,
    input  logic    i_d_req,
    input  logic    i_if_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic    i_rr_if_next,
`endif
    output logic    o_valid,
    output req_id_t o_id
);

    // Fixed-priority chain with an optional round-robin tie-break.
    always_comb begin
        o_valid = i_clr_req | i_d_req | i_if_req;
        o_id    = REQ_IF;
        if (i_clr_req) begin
            o_id = REQ_CLR;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (i_d_req && i_if_req) begin
            o_id = i_rr_if_next ? REQ_IF : REQ_D;
        end
`endif
        else if (i_d_req) begin
            o_id = REQ_D;
        end
        else begin
            o_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the cache controller between cache clear, data port and fetch port.
// Issues one command per grant, counts controller ready pulses, then returns
// the result with a one-cycle done pulse.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternating data/fetch grant).
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | controller gets NOP, pick a winner and latch its op
// ST_ISSUE   | one cycle of read/write/clear command on cacheCtrl
// ST_WAIT    | count ready pulses, capture read data into the port reg
// ST_CLRWAIT | fixed CLR_WAIT-cycle wait after a clear
// ST_DONE    | one-cycle done pulse to the granted port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int CLR_WAIT = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    localparam int CLR_CNT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;
    localparam logic [CLR_CNT_W-1:0] CLR_LOAD = CLR_CNT_W'(CLR_WAIT - 1);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    req_id_t              r_gnt;
    ctrl_t                r_op;
    logic                 r_ind;
    logic [1:0]           r_cnt;
    logic [CLR_CNT_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0]    r_if_data;
    logic [DATA_W-1:0]    r_d_rdata;
    logic                 r_commence;

    logic                 w_sel_valid;
    req_id_t              w_sel_id;
    ctrl_t                w_sel_op;
    logic                 w_sel_ind;
    logic                 w_last_pulse;

    ctrl_t                w_ctrl;
    logic                 w_ind;
    logic                 w_clr_done;
    logic                 w_d_done;
    logic                 w_if_done;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                 r_rr_if_next;
`endif

    mem_arb_select u_select (
        .i_clr_req    (bus.clrReq),
        .i_d_req      (bus.dReq),
        .i_if_req     (bus.ifReq),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_rr_if_next (r_rr_if_next),
`endif
        .o_valid      (w_sel_valid),
        .o_id         (w_sel_id)
    );

    // Command and indirect flag the winner would be issued with.
    always_comb begin
        w_sel_op  = CTRL_RD;
        w_sel_ind = 1'b0;
        case (w_sel_id)
            REQ_CLR: w_sel_op = CTRL_CLR;
            REQ_D: begin
                w_sel_op  = bus.dWrite ? CTRL_WR : CTRL_RD;
                w_sel_ind = bus.dIndirect;
            end
            default: w_sel_op = CTRL_RD;
        endcase
    end

    assign w_last_pulse = bus.cacheOutputReady &&
                          ((r_cnt + 2'd1) == pulses_needed(r_ind));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_sel_valid) w_next_state = ST_ISSUE;
            ST_ISSUE:   w_next_state = (r_gnt == REQ_CLR) ? ST_CLRWAIT : ST_WAIT;
            ST_WAIT:    if (w_last_pulse) w_next_state = ST_DONE;
            ST_CLRWAIT: if (r_clr_cnt == '0) w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched grant.
    always_comb begin
        w_ctrl     = CTRL_NOP;
        w_ind      = 1'b0;
        w_clr_done = 1'b0;
        w_d_done   = 1'b0;
        w_if_done  = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                w_ctrl = r_op;
                w_ind  = r_ind;
            end
            ST_WAIT: w_ind = r_ind;
            ST_DONE: begin
                w_clr_done = (r_gnt == REQ_CLR);
                w_d_done   = (r_gnt == REQ_D);
                w_if_done  = (r_gnt == REQ_IF);
            end
            default: ;
        endcase
    end

    // Address/data muxes follow the grant while busy and default to fetch in IDLE.
    always_comb begin
        w_addr  = bus.ifAddr;
        w_wdata = '0;
        if (r_state != ST_IDLE && r_gnt == REQ_D) begin
            w_addr  = bus.dAddr;
            w_wdata = bus.dWdata;
        end
    end

    // Grant latch, pulse/clear counters and port read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= REQ_IF;
            r_op      <= CTRL_NOP;
            r_ind     <= 1'b0;
            r_cnt     <= 2'd0;
            r_clr_cnt <= '0;
            r_if_data <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_gnt <= w_sel_id;
                        r_op  <= w_sel_op;
                        r_ind <= w_sel_ind;
                    end
                end
                ST_ISSUE: begin
                    r_cnt     <= 2'd0;
                    r_clr_cnt <= CLR_LOAD;
                end
                ST_WAIT: begin
                    if (bus.cacheOutputReady) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_gnt == REQ_IF) begin
                            r_if_data <= bus.cacheRdata;
                        end else if (r_gnt == REQ_D && r_op == CTRL_RD) begin
                            r_d_rdata <= bus.cacheRdata;
                        end
                    end
                end
                ST_CLRWAIT: begin
                    if (r_clr_cnt != '0) r_clr_cnt <= r_clr_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer moves to the other port after every data/fetch grant; clear leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_if_next <= 1'b0;
        end else if (r_state == ST_IDLE && w_sel_valid && w_sel_id != REQ_CLR) begin
            r_rr_if_next <= (w_sel_id == REQ_D);
        end
    end
`endif

    // Controller run enable: held low through reset so the controller restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commence <= 1'b0;
        end else begin
            r_commence <= 1'b1;
        end
    end

    assign bus.cacheCtrl     = w_ctrl;
    assign bus.cacheIndirect = w_ind;
    assign bus.cacheCommence = r_commence;
    assign bus.cacheAddr     = w_addr;
    assign bus.cacheWdata    = w_wdata;
    assign bus.clrDone       = w_clr_done;
    assign bus.dDone         = w_d_done;
    assign bus.ifDone        = w_if_done;
    assign bus.ifData        = r_if_data;
    assign bus.dRdata        = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single cache controller between three requesters: cache clear, data port (load/store, optionally indirect) and instruction-fetch port. Selects one requester, issues its command on the controller's `ctrl`/`indirect` inputs and holds the controller's address/data muxes. Counts `outputReady` pulses to detect completion, then returns the result with a one-cycle done pulse. Sits between the processor core and the cache controller in the memory module.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data word width
- `CLR_WAIT`, 2, cycles waited after issuing a clear before `clrDone`

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `clrReq`  in  1  cache clear request, held until `clrDone`
- `clrDone`  out  1  one-cycle pulse, clear complete
- `ifReq`  in  1  instruction fetch request, held with `ifAddr` until `ifDone`
- `ifAddr`  in  ADDR_W  fetch address
- `ifDone`  out  1  one-cycle pulse, `ifData` valid
- `ifData`  out  DATA_W  fetched word, registered, stable until next `ifDone`
- `dReq`  in  1  data request, held with operands until `dDone`
- `dWrite`  in  1  1 = store, 0 = load
- `dIndirect`  in  1  indirect access (controller makes two passes)
- `dAddr`  in  ADDR_W  data address
- `dWdata`  in  DATA_W  store data
- `dDone`  out  1  one-cycle pulse, access complete
- `dRdata`  out  DATA_W  load result, registered
- `cacheCtrl`  out  2  controller command: 00 clear, 01 nop, 10 read, 11 write
- `cacheIndirect`  out  1  indirect flag to controller
- `cacheCommence`  out  1  controller run enable (0 forces it to start)
- `cacheAddr`  out  ADDR_W  address of granted requester
- `cacheWdata`  out  DATA_W  write data of granted requester
- `cacheOutputReady`  in  1  controller pass-complete pulse
- `cacheRdata`  in  DATA_W  cache read data, valid with `cacheOutputReady`

## Operation
- States: IDLE, ISSUE, WAIT, CLRWAIT, DONE.
- IDLE: `cacheCtrl`=01. Picks a winner from pending requests; latches grant ID, op and indirect; goes to ISSUE. With no request it stays in IDLE.
- Priority: clear > data > fetch (fixed).
- ISSUE, one cycle: drives `cacheCtrl` = 10 (read) or 11 (write) or 00 (clear). Drives `cacheIndirect` = latched indirect. Fetch always uses read with indirect 0.
  - Clear goes to CLRWAIT.
  - All other ops clear the pulse counter and go to WAIT.
- WAIT: `cacheCtrl`=01, `cacheIndirect` held. Each `cacheOutputReady` increments a 2-bit counter and captures `cacheRdata` into the granted port's data register. It goes to DONE at the pulse where count reaches needed; needed = 2 if indirect else 1.
- CLRWAIT: counts `CLR_WAIT` cycles, then goes to DONE.
- DONE, one cycle: pulses the granted port's done. Goes to IDLE, so at most one grant per 2 idle/done cycles, which lets the controller return to start.
- `cacheAddr`/`cacheWdata` mux to the granted requester's inputs for ISSUE through DONE. They mux to fetch in IDLE.
- Write responses: `dRdata` is not updated on a write.
- Requests arriving during a busy transaction wait. A deasserted request mid-transaction is ignored: the transaction completes and done still pulses.
- Reset values: state IDLE; `cacheCommence`=0; `cacheCtrl`=01; `cacheIndirect`=0; all done pulses 0; `ifData`/`dRdata` 0; counter 0; RR pointer = data.
- `cacheCommence` is registered. It is 0 during `rst` and 1 from the first cycle after `rst` deasserts. Reset mid-transaction therefore aborts both arbiter and controller, and no done is issued.

## Timing
- Request seen in IDLE at cycle N gives ISSUE at N+1, WAIT from N+2.
- Read hit: `cacheOutputReady` at N+4, `dDone`/`ifDone` at N+5, IDLE at N+6, next ISSUE at N+7 at earliest.
- Misses stretch WAIT by the controller's RAM cycles; no arbiter timeout.
- Clear: ISSUE at N+1, `clrDone` at N+2+`CLR_WAIT`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when data and fetch are both pending, the grant alternates. A 1-bit pointer flips to the other port after each data/fetch grant. Clear keeps top priority and does not move the pointer.
- Undefined: fixed data > fetch priority; the pointer logic is absent.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum;
  - cache opcodes `CTRL_CLR`=00, `CTRL_NOP`=01, `CTRL_RD`=10, `CTRL_WR`=11;
  - requester ID constants `REQ_CLR`, `REQ_D`, `REQ_IF`.
- Sub-module `mem_arb_select` is the combinational winner pick (fixed or round-robin). The FSM, counters and registers stay in the top module.

## Test plan
- After reset release, fetch `ifAddr`=0x0040, read hit, with the controller model pulsing ready 3 cycles after ISSUE. Expect `cacheCtrl`=10 for exactly one cycle, `ifDone` at N+5, `ifData`=model data 0xBEEF.
- Indirect load `dAddr`=0x0010, with the model pulsing ready twice (0x0020 then 0x1234). Expect no `dDone` after the first pulse, then `dDone` with `dRdata`=0x1234.
- `dReq` and `ifReq` asserted together for 4 transactions. Fixed build: data wins every time fetch competes. `MEM_ARB_ROUND_ROBIN_EN`: grants alternate D, IF, D, IF.
- `clrReq` with `dReq` pending. Expect `cacheCtrl`=00 first, `clrDone` at N+4 with `CLR_WAIT`=2, then the data issue.
- `rst` asserted in WAIT of a store. Expect `cacheCommence`=0 next cycle, no `dDone`, state IDLE. Then a fresh store completes normally with `cacheCtrl`=11.
